// File: rtl/bram_fifo_pkg.sv
// ============================================================================
// Module      : bram_fifo_pkg
// Description : Shared mode constants and helper functions for the BRAM FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bram_fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // True when the parameter set describes a buildable FIFO.
    function automatic bit fifo_params_ok(input int dw, input int aw, input int fwft,
                                          input int af, input int ae);
        int depth;
        depth = 1 << aw;
        return (dw >= 1) && (aw >= 1) && (clog2(depth) == aw)
            && ((fwft == FIFO_MODE_STD) || (fwft == FIFO_MODE_FWFT))
            && (af >= 1) && (af <= depth)
            && (ae >= 0) && (ae <= depth - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bram_sdp.sv
// ============================================================================
// Module      : bram_sdp
// Description : Simple-dual-port RAM, one write port, one registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_sdp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int c_depth = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [c_depth];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Storage has no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Output latch carries a synchronous reset, which BRAM primitives support.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/bram_param_fifo.sv
// ============================================================================
// Module      : bram_param_fifo
// Description : Single-clock BRAM FIFO with optional FWFT, fill count and flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_param_fifo
    import bram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FWFT       = 0,
    parameter int AF_THRESH  = 2**ADDR_WIDTH - 1,
    parameter int AE_THRESH  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dest_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                c_depth_int = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_depth   = (ADDR_WIDTH+1)'(c_depth_int);
    localparam logic [ADDR_WIDTH:0] c_af      = (ADDR_WIDTH+1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] c_ae      = (ADDR_WIDTH+1)'(AE_THRESH);

    if (!fifo_params_ok(DATA_WIDTH, ADDR_WIDTH, FWFT, AF_THRESH, AE_THRESH)) begin : g_bad_params
        $error("bram_param_fifo: illegal parameter combination");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   fill_q, fill_d;
    logic                  full_q, empty_q, empty_d;
    logic                  af_q, ae_q, ov_q, un_q;
    logic                  w_wr_acc, w_rd_acc, w_ram_rd;
    logic [DATA_WIDTH-1:0] w_ram_dout;

    assign w_wr_acc = wr_en && !full_q && !rst;
    assign w_rd_acc = rd_en && !empty_q && !rst;
    assign wr_ptr_d = w_wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
    assign rd_ptr_d = w_ram_rd ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;

    always_comb begin
        fill_d = fill_q;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   fill_d = fill_q + (ADDR_WIDTH+1)'(1);
            2'b01:   fill_d = fill_q - (ADDR_WIDTH+1)'(1);
            default: fill_d = fill_q;
        endcase
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // The RAM read latch doubles as the output register; valid_q tracks it.
        logic                valid_q, valid_d;
        logic [ADDR_WIDTH:0] w_ram_count;

        assign w_ram_count = fill_q - {{ADDR_WIDTH{1'b0}}, valid_q};
        assign w_ram_rd    = (!valid_q || w_rd_acc) && (w_ram_count != '0) && !rst;
        assign empty_d     = !valid_d;

        always_comb begin
            valid_d = valid_q;
            if (w_ram_rd) begin
                valid_d = 1'b1;
            end else if (w_rd_acc) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= valid_d;
            end
        end
    end else begin : g_std
        assign w_ram_rd = w_rd_acc;
        assign empty_d  = (fill_d == '0);
    end

    bram_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (w_wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (src_data),
        .rd_en_i   (w_ram_rd),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (w_ram_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ov_q     <= 1'b0;
            un_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            full_q   <= (fill_d == c_depth);
            empty_q  <= empty_d;
            af_q     <= (fill_d >= c_af);
            ae_q     <= (fill_d <= c_ae);
            // Error flags are judged against the registered full/empty state.
            ov_q     <= ov_q | (wr_en & full_q);
            un_q     <= un_q | (rd_en & empty_q);
        end
    end

    assign dest_data    = w_ram_dout;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign fill_count   = fill_q;
    assign overflow     = ov_q;
    assign underflow    = un_q;

endmodule

`default_nettype wire

// File: tb/tb_bram_param_fifo.sv
// ============================================================================
// Module      : tb_bram_param_fifo
// Description : Directed vector bench for standard and FWFT FIFO instances.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_param_fifo;

    typedef struct packed {
        logic       rst;
        logic       wr;
        logic       rd;
        logic [7:0] din;
        logic [7:0] dout;
        logic       full;
        logic       empty;
        logic       af;
        logic       ae;
        logic [2:0] cnt;
        logic       ov;
        logic       un;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din_s = '0, din_f = '0;
    logic       wr_s = 1'b0, rd_s = 1'b0, wr_f = 1'b0, rd_f = 1'b0;
    logic [7:0] dout_s, dout_f;
    logic       full_s, empty_s, af_s, ae_s, ov_s, un_s;
    logic       full_f, empty_f, af_f, ae_f, ov_f, un_f;
    logic [2:0] cnt_s, cnt_f;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    bram_param_fifo #(
        .DATA_WIDTH (8), .ADDR_WIDTH (2), .FWFT (0), .AF_THRESH (3), .AE_THRESH (1)
    ) u_std (
        .clk (clk), .rst (rst), .src_data (din_s), .wr_en (wr_s), .rd_en (rd_s),
        .dest_data (dout_s), .full (full_s), .empty (empty_s), .almost_full (af_s),
        .almost_empty (ae_s), .fill_count (cnt_s), .overflow (ov_s), .underflow (un_s)
    );

    bram_param_fifo #(
        .DATA_WIDTH (8), .ADDR_WIDTH (2), .FWFT (1), .AF_THRESH (3), .AE_THRESH (1)
    ) u_fwft (
        .clk (clk), .rst (rst), .src_data (din_f), .wr_en (wr_f), .rd_en (rd_f),
        .dest_data (dout_f), .full (full_f), .empty (empty_f), .almost_full (af_f),
        .almost_empty (ae_f), .fill_count (cnt_f), .overflow (ov_f), .underflow (un_f)
    );

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Fields: rst wr rd din | dout full empty af ae cnt ov un
    task automatic add(input logic r, input logic w, input logic rd, input logic [7:0] d,
                       input logic [7:0] q, input logic f, input logic e, input logic af,
                       input logic ae, input logic [2:0] c, input logic ov, input logic un);
        vecs.push_back('{r, w, rd, d, q, f, e, af, ae, c, ov, un});
    endtask

    initial begin
        int k;
        int bubbles;
        bit started;
        logic [7:0] exp_q[$];

        // Fill, overflow, drain, underflow, reset.
        add(1,0,0,8'h00, 8'h00,0,1,0,1,3'd0,0,0);
        add(0,1,0,8'h11, 8'h00,0,0,0,1,3'd1,0,0);
        add(0,1,0,8'h22, 8'h00,0,0,0,0,3'd2,0,0);
        add(0,1,0,8'h33, 8'h00,0,0,1,0,3'd3,0,0);
        add(0,1,0,8'h44, 8'h00,1,0,1,0,3'd4,0,0);
        add(0,1,0,8'h55, 8'h00,1,0,1,0,3'd4,1,0);
        add(0,0,1,8'h00, 8'h11,0,0,1,0,3'd3,1,0);
        add(0,0,1,8'h00, 8'h22,0,0,0,0,3'd2,1,0);
        add(0,0,1,8'h00, 8'h33,0,0,0,1,3'd1,1,0);
        add(0,0,1,8'h00, 8'h44,0,1,0,1,3'd0,1,0);
        add(0,0,1,8'h00, 8'h44,0,1,0,1,3'd0,1,1);
        add(1,0,0,8'h00, 8'h00,0,1,0,1,3'd0,0,0);
        // Steady simultaneous traffic at fill_count 2 across pointer wrap.
        add(0,1,0,8'h01, 8'h00,0,0,0,1,3'd1,0,0);
        add(0,1,0,8'h02, 8'h00,0,0,0,0,3'd2,0,0);
        for (int i = 0; i < 8; i++) begin
            add(0,1,1,8'(i + 3), 8'(i + 1),0,0,0,0,3'd2,0,0);
        end
        add(0,0,1,8'h00, 8'h09,0,0,0,1,3'd1,0,0);
        add(0,0,1,8'h00, 8'h0A,0,1,0,1,3'd0,0,0);
        // Write while full with a simultaneous read: write is still refused.
        add(0,1,0,8'hB1, 8'h0A,0,0,0,1,3'd1,0,0);
        add(0,1,0,8'hB2, 8'h0A,0,0,0,0,3'd2,0,0);
        add(0,1,0,8'hB3, 8'h0A,0,0,1,0,3'd3,0,0);
        add(0,1,0,8'hB4, 8'h0A,1,0,1,0,3'd4,0,0);
        add(0,1,1,8'hC0, 8'hB1,0,0,1,0,3'd3,1,0);
        add(0,0,1,8'h00, 8'hB2,0,0,0,0,3'd2,1,0);
        // Reset mid-burst with wr_en high, then a read into the empty FIFO.
        add(1,0,0,8'h00, 8'h00,0,1,0,1,3'd0,0,0);
        add(0,1,0,8'h61, 8'h00,0,0,0,1,3'd1,0,0);
        add(0,1,0,8'h62, 8'h00,0,0,0,0,3'd2,0,0);
        add(0,1,0,8'h63, 8'h00,0,0,1,0,3'd3,0,0);
        add(1,1,0,8'h64, 8'h00,0,1,0,1,3'd0,0,0);
        add(0,0,1,8'h00, 8'h00,0,1,0,1,3'd0,0,1);

        for (int i = 0; i < vecs.size(); i++) begin
            rst   = vecs[i].rst;
            wr_s  = vecs[i].wr;
            rd_s  = vecs[i].rd;
            din_s = vecs[i].din;
            @(posedge clk);
            #1;
            chk("std_dout",  i, 32'(dout_s),  32'(vecs[i].dout));
            chk("std_full",  i, 32'(full_s),  32'(vecs[i].full));
            chk("std_empty", i, 32'(empty_s), 32'(vecs[i].empty));
            chk("std_af",    i, 32'(af_s),    32'(vecs[i].af));
            chk("std_ae",    i, 32'(ae_s),    32'(vecs[i].ae));
            chk("std_cnt",   i, 32'(cnt_s),   32'(vecs[i].cnt));
            chk("std_ovf",   i, 32'(ov_s),    32'(vecs[i].ov));
            chk("std_unf",   i, 32'(un_s),    32'(vecs[i].un));
            if (i == 0) begin
                chk("fwft_rst_empty", i, 32'(empty_f), 32'd1);
                chk("fwft_rst_dout",  i, 32'(dout_f),  32'd0);
                chk("fwft_rst_cnt",   i, 32'(cnt_f),   32'd0);
            end
        end
        wr_s = 1'b0;
        rd_s = 1'b0;

        // FWFT: single word falls through two edges after the write.
        wr_f  = 1'b1;
        din_f = 8'hA5;
        @(posedge clk); #1;
        wr_f = 1'b0;
        chk("fwft_cnt_n",   100, 32'(cnt_f),   32'd1);
        chk("fwft_empty_n", 100, 32'(empty_f), 32'd1);
        @(posedge clk); #1;
        chk("fwft_empty_n1", 101, 32'(empty_f), 32'd0);
        chk("fwft_dout_n1",  101, 32'(dout_f),  32'hA5);
        rd_f = 1'b1;
        @(posedge clk); #1;
        chk("fwft_pop_empty", 102, 32'(empty_f), 32'd1);
        chk("fwft_pop_cnt",   102, 32'(cnt_f),   32'd0);

        // FWFT stream of 10 words with rd_en held high throughout.
        k       = 0;
        bubbles = 0;
        started = 1'b0;
        for (int c = 0; c < 16; c++) begin
            wr_f  = (c < 10);
            din_f = 8'(8'h30 + c);
            if (c < 10) exp_q.push_back(8'(8'h30 + c));
            @(posedge clk); #1;
            if (!empty_f) begin
                started = 1'b1;
                if (k < exp_q.size()) begin
                    chk("fwft_stream_data", 200 + k, 32'(dout_f), 32'(exp_q[k]));
                end
                k++;
            end else if (started && k < 10) begin
                bubbles++;
            end
        end
        wr_f = 1'b0;
        rd_f = 1'b0;
        chk("fwft_stream_count",   300, 32'(k),       32'd10);
        chk("fwft_stream_bubbles", 301, 32'(bubbles), 32'd0);
        chk("fwft_end_empty",      302, 32'(empty_f), 32'd1);
        chk("fwft_end_cnt",        303, 32'(cnt_f),   32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bram_param_fifo.md
# bram_param_fifo

Parametrised single-clock FIFO built on a simple-dual-port block RAM; successor to `bram_std_fifo`. It adds a selectable first-word-fall-through (FWFT) read mode, an occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. Illegal accesses are absorbed safely instead of being forbidden. It is the general-purpose buffering stage between streaming producers and consumers in the same clock domain.

## Interface
- `DATA_WIDTH`, 8, word width in bits (>=1)
- `ADDR_WIDTH`, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (>=1)
- `FWFT`, 0, 0 = standard read latency, 1 = first-word-fall-through
- `AF_THRESH`, 2**ADDR_WIDTH-1, almost_full asserts when fill_count >= AF_THRESH (1..DEPTH)
- `AE_THRESH`, 1, almost_empty asserts when fill_count <= AE_THRESH (0..DEPTH-1)
- `clk`  in  1  sole clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `src_data`  in  DATA_WIDTH  write data
- `wr_en`  in  1  write request
- `rd_en`  in  1  read request (FWFT: pop/acknowledge of dest_data)
- `dest_data`  out  DATA_WIDTH  read data
- `full`  out  1  no free slot
- `empty`  out  1  standard: no stored word; FWFT: dest_data not valid
- `almost_full`  out  1  fill_count >= AF_THRESH
- `almost_empty`  out  1  fill_count <= AE_THRESH
- `fill_count`  out  ADDR_WIDTH+1  words held, 0..DEPTH, including the FWFT output register
- `overflow`  out  1  sticky: a write was attempted while full
- `underflow`  out  1  sticky: a read was attempted while empty

## Operation
- A write is accepted iff `wr_en && !full && !rst`. A read is accepted iff `rd_en && !empty && !rst`. Both may be accepted in the same cycle.
- Flags are evaluated on the registered state at the edge. A write while full is not admitted, even with a simultaneous accepted read.
- A rejected write is dropped and sets `overflow`. A rejected read leaves `dest_data` unchanged and sets `underflow`. Both flags clear only on `rst`.
- Pointers are ADDR_WIDTH bits wide and wrap modulo DEPTH.
- `fill_count` changes as follows: +1 on write only, -1 on read only, unchanged on a simultaneous write and read.
- All outputs are registered.
- Standard mode:
  - `dest_data` loads the head word on the edge after an accepted read and holds otherwise.
  - `empty` = (fill_count == 0).
- FWFT mode:
  - A one-word output register is prefetched from the RAM whenever it is invalid and the RAM holds data.
  - `empty` = !output_valid. `dest_data` is the head word whenever `!empty`.
  - An accepted read consumes it. The next word appears with no bubble if the RAM is non-empty.
- `full` = (fill_count == DEPTH) in both modes.
- Reset (any cycle, including mid-burst):
  - Contents are discarded and pointers zeroed.
  - Output values: `dest_data`=0, `full`=0, `empty`=1, `almost_full`=0, `almost_empty`=1, `fill_count`=0, `overflow`=0, `underflow`=0.
  - `wr_en`/`rd_en` are ignored in any cycle with `rst` high.

## Timing
- Standard mode:
  - Write at edge N: `fill_count`/`empty`/`full`/almost flags reflect it after edge N.
  - A read may be issued in cycle N+1.
  - Accepted read at edge N: `dest_data` is valid after edge N (1-cycle read latency) and holds until the next accepted read.
- FWFT mode:
  - Write into an empty FIFO at edge N: `fill_count`=1 after edge N; `empty` low and `dest_data` valid after edge N+1 (2-cycle fall-through).
  - Back-to-back reads sustain 1 word/clock.
- Both modes:
  - Throughput is one write and one read per clock.
  - The first cycle after `rst` deasserts accepts writes.

## Structure
- Package `bram_fifo_pkg`:
  - mode constants `FIFO_MODE_STD`=0, `FIFO_MODE_FWFT`=1
  - function `clog2`
  - parameter-legality checks (threshold ranges)
- Sub-module `bram_sdp`:
  - one write port, one read port, registered read
  - no reset on the storage array
  - so it infers block RAM
- Top level holds pointers, counter, flags and the FWFT output register (generate-selected by `FWFT`).

## Test plan
1. Standard mode (DATA_WIDTH=8, ADDR_WIDTH=2):
   - Reset, then write 0x11,0x22,0x33,0x44 -> `full`=1, `fill_count`=4, `almost_full`=1 after the 3rd write.
   - Four reads -> `dest_data` 0x11..0x44, each one cycle after its read; `empty`=1 at the end.
2. Full FIFO + `wr_en` with 0x55 -> data dropped, `overflow`=1 and sticky; subsequent reads return 0x11..0x44 only.
3. Empty FIFO + `rd_en` -> `underflow`=1, `dest_data` unchanged, `fill_count` stays 0; `rst` clears both flags.
4. Simultaneous write and read at `fill_count`=2 for 8 cycles with incrementing data -> `fill_count` stays 2, data order preserved across pointer wrap.
5. FWFT=1:
   - Write 0xA5 into the empty FIFO -> `empty` deasserts and `dest_data`=0xA5 two edges later.
   - Stream 10 words with continuous `rd_en` -> no bubbles, order preserved.
6. `rst` asserted at `fill_count`=3 with `wr_en`=1 -> next cycle all outputs hold their reset values; a following read attempt sets `underflow`.
